// File: rtl/max_group_sched_if.sv
// Handshake bundle for max_group_sched.
//   slave  : the scheduler itself
//   master : the surrounding logic (tree output, descriptor source, exp stage)
interface max_group_sched_if #(
   parameter int DATA_W = 16,
   parameter int MODE_W = 4,
   parameter int TAG_W  = 16
);
   logic              i_en;
   logic              i_desc_valid;
   logic [MODE_W-1:0] i_length_mode;
   logic              o_desc_ready;
   logic              i_valid_max;
   logic [DATA_W-1:0] i_loc_max;
   logic [TAG_W-1:0]  i_temp;
   logic              o_ready_max;
   logic              o_valid_max;
   logic [DATA_W-1:0] o_global_max;
   logic [MODE_W-1:0] o_length_mode_byp;
   logic [TAG_W-1:0]  o_temp;
   logic              i_out_ready;
   logic              o_busy;
   logic              o_timeout;

   modport slave (
      input  i_en, i_desc_valid, i_length_mode, i_valid_max, i_loc_max, i_temp, i_out_ready,
      output o_desc_ready, o_ready_max, o_valid_max, o_global_max, o_length_mode_byp,
             o_temp, o_busy, o_timeout
   );

   modport master (
      output i_en, i_desc_valid, i_length_mode, i_valid_max, i_loc_max, i_temp, i_out_ready,
      input  o_desc_ready, o_ready_max, o_valid_max, o_global_max, o_length_mode_byp,
             o_temp, o_busy, o_timeout
   );
endinterface

// File: rtl/max_group_sched.sv
// max_group_sched: takes one group descriptor, reduces the following N = mode+1
// local-max beats to a signed maximum and presents one result beat carrying the
// group mode and the last beat's tag.
// Optional feature macro: MAX_SCHED_TIMEOUT_EN (idle-beat abort in ACCUM).
module max_group_sched #(
   parameter int DATA_W      = 16,
   parameter int MODE_W      = 4,
   parameter int TAG_W       = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   max_group_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

   state_t                   state;
   logic [4:0]               cnt;       // 5 bits so mode 4'hF loads 16 without wrap
   logic                     seen;      // a beat has been taken in this group
   logic signed [DATA_W-1:0] run_max;
   logic [MODE_W-1:0]        mode_q;
   logic [TAG_W-1:0]         tag_q;
   logic                     valid_q;
   logic                     busy_q;
   logic                     timeout_hit;

   logic desc_rdy, beat_rdy, desc_hs, beat_hs, res_hs;

   // Ready only in the accepting state; the reset term keeps both low during reset.
   assign desc_rdy = bus.i_en & ~i_rst & (state == IDLE);
   assign beat_rdy = bus.i_en & ~i_rst & (state == ACCUM);
   assign desc_hs  = bus.i_desc_valid & desc_rdy;
   assign beat_hs  = bus.i_valid_max & beat_rdy;
   assign res_hs   = valid_q & bus.i_out_ready & bus.i_en;

   assign bus.o_desc_ready      = desc_rdy;
   assign bus.o_ready_max       = beat_rdy;
   assign bus.o_valid_max       = valid_q;
   assign bus.o_global_max      = run_max;
   assign bus.o_length_mode_byp = mode_q;
   assign bus.o_temp            = tag_q;
   assign bus.o_busy            = busy_q;

`ifdef MAX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] idle_cnt;
   logic          timeout_q;

   assign timeout_hit = (state == ACCUM) & bus.i_en & ~beat_hs &
                        (idle_cnt == TW'(TIMEOUT_CYC - 1));
   assign bus.o_timeout = timeout_q;

   // Count consecutive enabled beat-less cycles in ACCUM; flag an aborted group.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (bus.i_en) begin
         if (state != ACCUM || beat_hs)
            idle_cnt <= '0;
         else if (!timeout_hit)
            idle_cnt <= idle_cnt + 1'b1;
         if (timeout_hit)
            timeout_q <= 1'b1;
         else if (res_hs)
            timeout_q <= 1'b0;
      end
   end
`else
   assign timeout_hit   = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   // Group sequencer: descriptor -> N beats reduced to a signed max -> one result.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         seen    <= 1'b0;
         run_max <= '0;
         mode_q  <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (bus.i_en) begin
         case (state)
            IDLE: if (desc_hs) begin
               mode_q  <= bus.i_length_mode;
               cnt     <= 5'(bus.i_length_mode) + 5'd1;
               seen    <= 1'b0;
               run_max <= '0;   // an aborted empty group reports 0
               busy_q  <= 1'b1;
               state   <= ACCUM;
            end
            ACCUM: begin
               if (beat_hs) begin
                  // Strict > keeps the earlier value on ties.
                  if (!seen || ($signed(bus.i_loc_max) > run_max))
                     run_max <= $signed(bus.i_loc_max);
                  seen  <= 1'b1;
                  tag_q <= bus.i_temp;
                  cnt   <= cnt - 5'd1;
                  if (cnt == 5'd1) begin
                     valid_q <= 1'b1;
                     state   <= EMIT;
                  end
               end else if (timeout_hit) begin
                  valid_q <= 1'b1;
                  state   <= EMIT;
               end
            end
            EMIT: if (res_hs) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_max_group_sched.sv
// Self-checking bench for max_group_sched: scoreboard of expected results,
// monitor pops on every result handshake.
module tb_max_group_sched;
   localparam int DATA_W = 16;
   localparam int MODE_W = 4;
   localparam int TAG_W  = 16;
   localparam int TOUT   = 8;

   typedef struct packed {
      logic [DATA_W-1:0] mx;
      logic [MODE_W-1:0] mode;
      logic [TAG_W-1:0]  tag;
      logic              to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   results = 0;
   exp_t sb[$];
   exp_t mon_e;

   max_group_sched_if #(.DATA_W(DATA_W), .MODE_W(MODE_W), .TAG_W(TAG_W)) bus ();

   max_group_sched #(.DATA_W(DATA_W), .MODE_W(MODE_W), .TAG_W(TAG_W), .TIMEOUT_CYC(TOUT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Monitor: every result handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && bus.o_valid_max && bus.i_out_ready && bus.i_en) begin
         results++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result max=%h mode=%h tag=%h", bus.o_global_max,
                     bus.o_length_mode_byp, bus.o_temp);
         end else begin
            mon_e = sb.pop_front();
            if ({bus.o_global_max, bus.o_length_mode_byp, bus.o_temp, bus.o_timeout} !== mon_e) begin
               errors++;
               $display("FAIL result got max=%h mode=%h tag=%h to=%b want max=%h mode=%h tag=%h to=%b",
                        bus.o_global_max, bus.o_length_mode_byp, bus.o_temp, bus.o_timeout,
                        mon_e.mx, mon_e.mode, mon_e.tag, mon_e.to);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_desc(input logic [MODE_W-1:0] m);
      bus.i_desc_valid  = 1'b1;
      bus.i_length_mode = m;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_desc_ready) begin
            tick();
            bus.i_desc_valid = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL desc_accept got no ready want ready within 200 cycles");
      bus.i_desc_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] v, input logic [TAG_W-1:0] t);
      bus.i_valid_max = 1'b1;
      bus.i_loc_max   = v;
      bus.i_temp      = t;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_ready_max) begin
            tick();
            bus.i_valid_max = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL beat_accept got no ready want ready within 200 cycles");
      bus.i_valid_max = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      bus.i_en = 1'b1; bus.i_desc_valid = 1'b0; bus.i_valid_max = 1'b0;
      bus.i_out_ready = 1'b1; bus.i_length_mode = '0; bus.i_loc_max = '0; bus.i_temp = '0;
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.o_valid_max, bus.o_global_max, bus.o_length_mode_byp, bus.o_temp, bus.o_busy,
           bus.o_timeout, bus.o_desc_ready, bus.o_ready_max} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b max=%h mode=%h tag=%h busy=%b to=%b dr=%b rm=%b want all 0",
                  bus.o_valid_max, bus.o_global_max, bus.o_length_mode_byp, bus.o_temp,
                  bus.o_busy, bus.o_timeout, bus.o_desc_ready, bus.o_ready_max);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.o_desc_ready !== 1'b1 || bus.o_ready_max !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready got dr=%b rm=%b want dr=1 rm=0", bus.o_desc_ready, bus.o_ready_max);
      end
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] v [5];
      v = '{16'd3, -16'sd7, 16'd25, 16'd10, 16'd25};
      sb.push_back('{16'd25, 4'd4, 16'hABC4, 1'b0});
      send_desc(4'd4);
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_ready_max !== 1'b1) begin
         errors++;
         $display("FAIL accum_entry got busy=%b rm=%b want 1 1", bus.o_busy, bus.o_ready_max);
      end
      for (int i = 0; i < 5; i++) begin
         send_beat(v[i], 16'hABC0 + 16'(i));
         if (i == 3) begin
            checks++;
            if (bus.o_valid_max !== 1'b0) begin
               errors++;
               $display("FAIL early_valid got %b want 0", bus.o_valid_max);
            end
         end
      end
      checks++;
      if (bus.o_valid_max !== 1'b1) begin
         errors++;
         $display("FAIL valid_latency got %b want 1 one cycle after last beat", bus.o_valid_max);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int  r0;
      time t_prev, t_now;
      r0 = results;
      t_prev = 0;
      for (int m = 0; m < 16; m++) begin
         sb.push_back('{16'(10 * m + 20), 4'(m), {4'(m), 12'(m)}, 1'b0});
         send_desc(4'(m));
         t_now = $time;
         if (m > 0) begin
            checks++;
            if (t_now - t_prev != time'((m + 2) * 10)) begin
               errors++;
               $display("FAIL group_period got %0t want %0d cycles*10 for mode %0d",
                        t_now - t_prev, m + 2, m - 1);
            end
         end
         t_prev = t_now;
         for (int i = 0; i <= m; i++)
            send_beat((i == (m + 1) / 2) ? 16'(10 * m + 20) : 16'(-50 + 3 * i),
                      {4'(m), 12'(i)});
      end
      wait_drain();
      tick();
      checks++;
      if (results - r0 != 16) begin
         errors++;
         $display("FAIL b2b_count got %0d want 16", results - r0);
      end
   endtask

   task automatic test_negative();
      sb.push_back('{16'hFFFF, 4'd2, 16'h0002, 1'b0});
      send_desc(4'd2);
      send_beat(16'hFFFF, 16'h0000);
      send_beat(16'h8000, 16'h0001);
      send_beat(16'hFFFB, 16'h0002);
      wait_drain();
      sb.push_back('{16'h8000, 4'd0, 16'h0010, 1'b0});
      send_desc(4'd0);
      send_beat(16'h8000, 16'h0010);
      wait_drain();
      sb.push_back('{16'h8000, 4'd2, 16'h0022, 1'b0});
      send_desc(4'd2);
      for (int i = 0; i < 3; i++) send_beat(16'h8000, 16'h0020 + 16'(i));
      wait_drain();
   endtask

   task automatic test_stall();
      logic [DATA_W+MODE_W+TAG_W-1:0] snap;
      int r0, bad;
      bus.i_out_ready = 1'b0;
      sb.push_back('{16'd100, 4'd1, 16'h5501, 1'b0});
      send_desc(4'd1);
      send_beat(16'd7, 16'h5500);
      send_beat(16'd100, 16'h5501);
      snap = {bus.o_global_max, bus.o_length_mode_byp, bus.o_temp};
      r0 = results;
      bus.i_desc_valid = 1'b1; bus.i_valid_max = 1'b1; bus.i_loc_max = 16'h7FFF;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.o_valid_max !== 1'b1 || bus.o_desc_ready !== 1'b0 || bus.o_ready_max !== 1'b0 ||
             {bus.o_global_max, bus.o_length_mode_byp, bus.o_temp} !== snap) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold got %0d bad cycles want 0", bad);
      end
      tick();
      bus.i_desc_valid = 1'b0; bus.i_valid_max = 1'b0;
      bus.i_out_ready = 1'b1;
      wait_drain();
      tick(); tick();
      checks++;
      if (results - r0 != 1) begin
         errors++;
         $display("FAIL stall_count got %0d want 1", results - r0);
      end
   endtask

   task automatic test_enable_gap();
      int bad;
      sb.push_back('{16'd40, 4'd3, 16'h0E03, 1'b0});
      send_desc(4'd3);
      send_beat(16'd5, 16'h0E00);
      send_beat(16'd40, 16'h0E01);
      bus.i_en = 1'b0;
      bus.i_valid_max = 1'b1; bus.i_loc_max = -16'sd3; bus.i_temp = 16'h0E02;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.o_ready_max !== 1'b0 || bus.o_desc_ready !== 1'b0 || bus.o_busy !== 1'b1) bad++;
      end
      tick();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL en_gap_ready got %0d bad cycles want 0", bad);
      end
      bus.i_en = 1'b1;
      send_beat(-16'sd3, 16'h0E02);
      send_beat(16'd12, 16'h0E03);
      bus.i_en = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.o_valid_max !== 1'b1 || sb.size() != 1) bad++;
      end
      tick();
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL en_gap_hold got %0d bad cycles want 0", bad);
      end
      bus.i_en = 1'b1;
      wait_drain();
   endtask

   task automatic test_reset_mid();
      int r0;
      r0 = results;
      send_desc(4'd7);
      for (int i = 0; i < 3; i++) send_beat(16'd300 + 16'(i), 16'h7700 + 16'(i));
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_valid_max, bus.o_global_max, bus.o_length_mode_byp, bus.o_temp, bus.o_busy,
           bus.o_timeout, bus.o_desc_ready, bus.o_ready_max} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got v=%b max=%h mode=%h tag=%h busy=%b want all 0",
                  bus.o_valid_max, bus.o_global_max, bus.o_length_mode_byp, bus.o_temp, bus.o_busy);
      end
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (results != r0) begin
         errors++;
         $display("FAIL midreset_result got %0d results want 0", results - r0);
      end
      sb.push_back('{16'hFFFE, 4'd1, 16'h0B01, 1'b0});
      send_desc(4'd1);
      send_beat(-16'sd9, 16'h0B00);
      send_beat(-16'sd2, 16'h0B01);
      wait_drain();
   endtask

   task automatic test_timeout();
`ifdef MAX_SCHED_TIMEOUT_EN
      sb.push_back('{16'd9, 4'd5, 16'h0C01, 1'b1});
      send_desc(4'd5);
      send_beat(16'd4, 16'h0C00);
      send_beat(16'd9, 16'h0C01);
      for (int i = 0; i < TOUT - 1; i++) tick();
      checks++;
      if (bus.o_valid_max !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early got valid=%b want 0", bus.o_valid_max);
      end
      wait_drain();
      tick();
      checks++;
      if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear got to=%b busy=%b want 0 0", bus.o_timeout, bus.o_busy);
      end
`else
      int seen_v;
      send_desc(4'd5);
      send_beat(16'd4, 16'h0C00);
      send_beat(16'd9, 16'h0C01);
      seen_v = 0;
      for (int i = 0; i < 4 * TOUT; i++) begin
         @(negedge clk);
         if (bus.o_valid_max !== 1'b0 || bus.o_timeout !== 1'b0) seen_v++;
      end
      tick();
      checks++;
      if (seen_v != 0 || bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL no_timeout got %0d valid cycles busy=%b want 0 and busy=1", seen_v, bus.o_busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_negative();
      test_stall();
      test_enable_gap();
      test_reset_mid();
      test_timeout();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_queue got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish before 500us");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/max_group_sched.md
# max_group_sched

Sequencer for the softmax-approximation max-forwarding stage. It accepts one group descriptor (length mode), then consumes exactly that many local-max beats from the tree. It reduces them to a signed global maximum and presents one result beat with the descriptor's mode and the last beat's tag bypassed. It sits between the local-max tree output and the subtract/exp stage, and applies back-pressure to both sides.

## Interface
- DATA_W, 16, signed local/global max width
- MODE_W, 4, length-mode width
- TAG_W, 16, sideband tag width (i_temp/o_temp)
- TIMEOUT_CYC, 255, idle-beat limit in ACCUM (used only with MAX_SCHED_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  global enable; low freezes all state
- i_desc_valid  in  1  descriptor valid
- i_length_mode  in  MODE_W  group length mode; group holds N = i_length_mode + 1 beats (1..16)
- o_desc_ready  out  1  descriptor accepted when valid & ready
- i_valid_max  in  1  local-max beat valid
- i_loc_max  in  DATA_W  signed local maximum
- i_temp  in  TAG_W  per-beat tag
- o_ready_max  out  1  beat accepted when valid & ready
- o_valid_max  out  1  global-max result valid
- o_global_max  out  DATA_W  signed group maximum
- o_length_mode_byp  out  MODE_W  mode of the reported group
- o_temp  out  TAG_W  tag of the group's last beat
- i_out_ready  in  1  downstream accepts result
- o_busy  out  1  state != IDLE
- o_timeout  out  1  result is an aborted group (tied 0 without macro)

## Operation
- FSM: IDLE, ACCUM, EMIT.
- IDLE: o_desc_ready = i_en. On desc handshake:
  - latch mode;
  - remaining count = N;
  - clear first-beat flag;
  - go to ACCUM.
- ACCUM: o_ready_max = i_en.
  - First accepted beat loads the running max unconditionally.
  - Each later beat replaces it if $signed(i_loc_max) > running max. Ties keep the earlier value.
  - Every beat latches i_temp and decrements the count.
  - The beat that takes the count to 0 moves the FSM to EMIT.
- EMIT: o_valid_max = 1; outputs are held stable until i_out_ready. On handshake, return to IDLE.
- Beats presented in IDLE or EMIT are not accepted (o_ready_max = 0).
- Descriptors presented outside IDLE are not accepted.
- i_en = 0: FSM, counters and outputs are held; o_desc_ready = o_ready_max = 0. A pending o_valid_max stays high, but the handshake does not complete.
- Counter width: 5 bits. Mode 4'hF gives 16 beats with no wrap.
- Comparison is full-width signed. 16'h8000 is the most negative value; a group of all 16'h8000 reports 16'h8000.

## Timing
- Reset (async assert, sync release): state IDLE.
  - o_valid_max, o_global_max, o_length_mode_byp, o_temp, o_busy, o_timeout all 0.
  - o_desc_ready, o_ready_max 0 while i_rst is high.
- Descriptor handshake at edge k gives ACCUM from cycle k+1. The first beat is acceptable in cycle k+1.
- Last beat accepted at edge m gives o_valid_max high in cycle m+1 (1-cycle latency).
- Result handshake at edge r gives IDLE in cycle r+1. The next descriptor is accepted at the earliest at edge r+1, so there is one bubble cycle between groups.
- Minimum group period: N + 2 cycles with no stalls.
- Reset asserted mid-group: the group is discarded and no result is emitted.

## Configuration
- MAX_SCHED_TIMEOUT_EN defined:
  - A cycle counter in ACCUM clears on each accepted beat.
  - When TIMEOUT_CYC consecutive cycles pass with i_en = 1 and no beat, the FSM goes to EMIT with the partial max (0 if no beat was received) and o_timeout = 1.
  - o_timeout clears on the result handshake.
- Macro undefined: no counter; ACCUM waits indefinitely; o_timeout tied 0.

## Test plan
- Mode 4 (5 beats) with beats 3, -7, 25, 10, 25, tags 0xABC0..0xABC4, i_out_ready = 1: one result with max 25, mode 4, tag 0xABC4; o_valid_max rises 1 cycle after the 5th beat.
- Modes 0..15 back-to-back, each group's middle beat = 10·mode + 20: 16 results in order with the correct max and mode; no result is dropped and none is duplicated.
- All-negative group, mode 2: beats -1, -32768, -5 → max -1. A group of a single -32768 → 0x8000.
- i_out_ready held low 10 cycles in EMIT: outputs are stable; o_desc_ready = 0 and o_ready_max = 0 throughout; exactly one result after release.
- Toggle i_en low for 3 cycles mid-group (mode 3), and assert i_rst mid-group: enable gap yields the same result as without the gap. Reset yields all outputs 0, no result, and the next group is clean.
- MAX_SCHED_TIMEOUT_EN with TIMEOUT_CYC = 8, mode 5, only 2 beats (4, 9) sent: after 8 idle cycles, result 9 with o_timeout = 1. Without the macro, no result appears.
